// File: rtl/controle_irrigacao.sv
// Irrigation sequencer: timed watering cycles, valve enables, counters,
// display scan strobe and tank-empty alarm.
// Ports: Clock, Reset_n (async low); Umid, Modo, Nv in;
//        Limp, Mist, ContA, ContB, S, Alarme out (all registered).
module controle_irrigacao #(
   parameter int CLK_DIV  = 50000000,
   parameter int SCAN_DIV = 50000,
   parameter int T_IRRIG  = 9,
   parameter int T_PAUSA  = 5,
   parameter int N_CICLOS = 3
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       Umid,
   input  logic       Modo,
   input  logic [1:0] Nv,
   output logic       Limp,
   output logic       Mist,
   output logic [3:0] ContA,
   output logic [1:0] ContB,
   output logic       S,
   output logic       Alarme
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      REGA   = 2'd1,
      PAUSA  = 2'd2,
      FIM    = 2'd3
   } estado_t;

   estado_t       state, state_n;
   logic [PW-1:0] presc;
   logic [SW-1:0] scan;
   logic          tick;
   logic          vazio;
   logic          modo_l, modo_n;
   logic [3:0]    cont_a_n;
   logic [1:0]    cont_b_n;
   logic [1:0]    cont_b_inc;

   assign tick       = (presc == PW'(CLK_DIV - 1));
   assign vazio      = (Nv == 2'b00);
   assign cont_b_inc = ContB + 2'd1;

   // Free-running second prescaler, independent of the FSM
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Display scan strobe: toggles each time the scan counter wraps
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         scan <= '0;
         S    <= 1'b0;
      end else if (scan == SW'(SCAN_DIV - 1)) begin
         scan <= '0;
         S    <= ~S;
      end else begin
         scan <= scan + SW'(1);
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= OCIOSO;
         ContA  <= 4'd0;
         ContB  <= 2'd0;
         modo_l <= 1'b0;
         Limp   <= 1'b0;
         Mist   <= 1'b0;
         Alarme <= 1'b0;
      end else begin
         state  <= state_n;
         ContA  <= cont_a_n;
         ContB  <= cont_b_n;
         modo_l <= modo_n;
         // Valves follow the next state so they open/close on the
         // same edge as the transition
         Limp   <= (state_n == REGA) && !modo_n;
         Mist   <= (state_n == REGA) && modo_n;
         Alarme <= vazio;
      end
   end

   always_comb begin
      state_n  = state;
      cont_a_n = ContA;
      cont_b_n = ContB;
      modo_n   = modo_l;
      unique case (state)
         OCIOSO: begin
            cont_a_n = 4'd0;
            if (Umid && !vazio) begin
               state_n  = REGA;
               cont_a_n = 4'(T_IRRIG);
               cont_b_n = 2'd0;
               modo_n   = Modo;
            end
         end
         REGA: begin
            if (vazio) begin
               state_n  = OCIOSO;
               cont_a_n = 4'd0;
            end else if (tick && ContA > 4'd1) begin
               cont_a_n = ContA - 4'd1;
            end else if (tick && ContA == 4'd1) begin
               cont_b_n = cont_b_inc;
               if (cont_b_inc == 2'(N_CICLOS)) begin
                  state_n  = FIM;
                  cont_a_n = 4'd0;
               end else begin
                  state_n  = PAUSA;
                  cont_a_n = 4'(T_PAUSA);
               end
            end
         end
         PAUSA: begin
            if (vazio) begin
               state_n  = OCIOSO;
               cont_a_n = 4'd0;
            end else if (tick && ContA > 4'd1) begin
               cont_a_n = ContA - 4'd1;
            end else if (tick && ContA == 4'd1) begin
               if (Umid) begin
                  state_n  = REGA;
                  cont_a_n = 4'(T_IRRIG);
                  modo_n   = Modo;
               end else begin
                  state_n  = FIM;
                  cont_a_n = 4'd0;
               end
            end
         end
         FIM: begin
            cont_a_n = 4'd0;
            if (!Umid) begin
               state_n = OCIOSO;
            end
         end
         default: begin
            state_n  = OCIOSO;
            cont_a_n = 4'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao with a short tick and scan
// period; expected values are hand-derived from edge counts.
module tb_controle_irrigacao;

   logic       clk;
   logic       rst_n;
   logic       umid;
   logic       modo;
   logic [1:0] nv;
   logic       limp;
   logic       mist;
   logic [3:0] cont_a;
   logic [1:0] cont_b;
   logic       s;
   logic       alarme;

   int errors = 0;
   int checks = 0;
   int cyc;

   controle_irrigacao #(
      .CLK_DIV (4),
      .SCAN_DIV(2),
      .T_IRRIG (3),
      .T_PAUSA (2),
      .N_CICLOS(2)
   ) dut (
      .Clock  (clk),
      .Reset_n(rst_n),
      .Umid   (umid),
      .Modo   (modo),
      .Nv     (nv),
      .Limp   (limp),
      .Mist   (mist),
      .ContA  (cont_a),
      .ContB  (cont_b),
      .S      (s),
      .Alarme (alarme)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since reset release; the 1 s tick lands on the
   // edges where cyc is a multiple of 4, S equals bit 1 of cyc.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic to_tick();
      step(1);
      for (int i = 0; i < 4 && (cyc % 4) != 0; i++) step(1);
   endtask

   task automatic valves(input string tag, input logic l,
                         input logic m);
      check({tag, ".limp"}, {7'd0, limp}, {7'd0, l});
      check({tag, ".mist"}, {7'd0, mist}, {7'd0, m});
   endtask

   initial begin
      rst_n = 1'b0;
      umid  = 1'b0;
      modo  = 1'b0;
      nv    = 2'b11;
      #12;
      valves("rst", 1'b0, 1'b0);
      check("rst.conta", {4'd0, cont_a}, 8'd0);
      check("rst.contb", {6'd0, cont_b}, 8'd0);
      check("rst.s", {7'd0, s}, 8'd0);
      check("rst.alarme", {7'd0, alarme}, 8'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: idle with scan strobe running
      step(20);
      valves("idle", 1'b0, 1'b0);
      check("idle.conta", {4'd0, cont_a}, 8'd0);
      check("idle.contb", {6'd0, cont_b}, 8'd0);
      check("idle.alarme", {7'd0, alarme}, 8'd0);
      check("s.c20", {7'd0, s}, 8'd0);
      step(1);
      check("s.c21", {7'd0, s}, 8'd0);
      step(1);
      check("s.c22", {7'd0, s}, 8'd1);

      // 2: full clean-water session
      umid = 1'b1;
      modo = 1'b0;
      step(1);
      valves("rega1", 1'b1, 1'b0);
      check("rega1.conta", {4'd0, cont_a}, 8'd3);
      check("rega1.contb", {6'd0, cont_b}, 8'd0);
      to_tick();
      check("rega1.t1", {4'd0, cont_a}, 8'd2);
      to_tick();
      check("rega1.t2", {4'd0, cont_a}, 8'd1);
      to_tick();
      valves("pausa1", 1'b0, 1'b0);
      check("pausa1.contb", {6'd0, cont_b}, 8'd1);
      check("pausa1.conta", {4'd0, cont_a}, 8'd2);
      to_tick();
      check("pausa1.t1", {4'd0, cont_a}, 8'd1);
      to_tick();
      valves("rega2", 1'b1, 1'b0);
      check("rega2.conta", {4'd0, cont_a}, 8'd3);
      to_tick();
      to_tick();
      check("rega2.t2", {4'd0, cont_a}, 8'd1);
      to_tick();
      valves("fim", 1'b0, 1'b0);
      check("fim.contb", {6'd0, cont_b}, 8'd2);
      check("fim.conta", {4'd0, cont_a}, 8'd0);
      umid = 1'b0;
      step(1);
      valves("ocioso", 1'b0, 1'b0);
      check("ocioso.contb", {6'd0, cont_b}, 8'd2);

      // 3: mode latched on entry, relatched on the next cycle
      umid = 1'b1;
      modo = 1'b1;
      step(1);
      valves("mix.entry", 1'b0, 1'b1);
      check("mix.contb", {6'd0, cont_b}, 8'd0);
      check("mix.conta", {4'd0, cont_a}, 8'd3);
      modo = 1'b0;
      step(1);
      valves("mix.hold", 1'b0, 1'b1);
      to_tick();
      to_tick();
      valves("mix.late", 1'b0, 1'b1);
      check("mix.late.conta", {4'd0, cont_a}, 8'd1);
      to_tick();
      valves("mix.pausa", 1'b0, 1'b0);
      to_tick();
      to_tick();
      valves("relatch", 1'b1, 1'b0);
      check("relatch.conta", {4'd0, cont_a}, 8'd3);

      // 4: tank empties mid-watering
      to_tick();
      check("drain.pre", {4'd0, cont_a}, 8'd2);
      nv = 2'b00;
      step(1);
      valves("drain", 1'b0, 1'b0);
      check("drain.conta", {4'd0, cont_a}, 8'd0);
      check("drain.alarme", {7'd0, alarme}, 8'd1);
      nv = 2'b11;
      step(1);
      valves("refill", 1'b1, 1'b0);
      check("refill.conta", {4'd0, cont_a}, 8'd3);
      check("refill.contb", {6'd0, cont_b}, 8'd0);
      check("refill.alarme", {7'd0, alarme}, 8'd0);

      // 5: dryness request drops during the pause
      to_tick();
      to_tick();
      to_tick();
      check("dry.pausa.contb", {6'd0, cont_b}, 8'd1);
      umid = 1'b0;
      to_tick();
      valves("dry.pausa", 1'b0, 1'b0);
      to_tick();
      valves("dry.fim", 1'b0, 1'b0);
      check("dry.fim.conta", {4'd0, cont_a}, 8'd0);
      check("dry.fim.contb", {6'd0, cont_b}, 8'd1);
      step(1);
      valves("dry.ocioso", 1'b0, 1'b0);
      umid = 1'b1;
      step(1);
      valves("dry.restart", 1'b1, 1'b0);
      check("dry.restart.conta", {4'd0, cont_a}, 8'd3);

      // 6: asynchronous reset in the middle of the second cycle
      to_tick();
      to_tick();
      to_tick();
      to_tick();
      to_tick();
      to_tick();
      check("arst.pre.contb", {6'd0, cont_b}, 8'd1);
      check("arst.pre.conta", {4'd0, cont_a}, 8'd2);
      valves("arst.pre", 1'b1, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      valves("arst", 1'b0, 1'b0);
      check("arst.conta", {4'd0, cont_a}, 8'd0);
      check("arst.contb", {6'd0, cont_b}, 8'd0);
      check("arst.s", {7'd0, s}, 8'd0);
      #1 rst_n = 1'b1;
      step(1);
      valves("arst.restart", 1'b1, 1'b0);
      check("arst.restart.conta", {4'd0, cont_a}, 8'd3);
      check("arst.restart.contb", {6'd0, cont_b}, 8'd0);
      step(1);
      check("arst.s.c2", {7'd0, s}, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
